// File: rtl/perf_cntr_readout.sv
// Software read port for the 64-bit performance counters: 32-bit reads with a
// low-half snapshot so a following high-half read of the same counter is coherent.
module perf_cntr_readout #(
   parameter int NUM_CNTR = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  perf_start,
   input  logic [NUM_CNTR*64-1:0] cntr_bus,
   input  logic                  rd_req,
   input  logic [15:0]           rd_sel,
   output logic                  rd_ack,
   output logic                  rd_err,
   output logic [31:0]           perf_cntr_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;
   typedef struct packed {
      logic       hi;
      logic [3:0] idx;
   } sel_t;

   localparam logic [4:0] NUM_LIM = 5'(NUM_CNTR);

   state_t            state, state_nxt;
   sel_t              sel_q;
   logic [63:0]       cap_q;
   logic [31:0]       shadow_hi;
   logic [3:0]        shadow_idx;
   logic              shadow_vld;
   logic [15:0][63:0] cntr_arr;
   logic              idx_ok;
   logic              shadow_hit;
   logic              unused_sel;

   // Pad to 16 entries so any 4-bit index selects something; missing counters read 0.
   generate
      for (genvar k = 0; k < 16; k++) begin : g_cntr
         if (k < NUM_CNTR) begin : g_live
            assign cntr_arr[k] = cntr_bus[64*k +: 64];
         end else begin : g_pad
            assign cntr_arr[k] = '0;
         end
      end
   endgenerate

   assign idx_ok     = {1'b0, sel_q.idx} < NUM_LIM;
   assign shadow_hit = shadow_vld && (shadow_idx == sel_q.idx);
   assign busy       = (state != IDLE);
   assign unused_sel = ^rd_sel[15:5];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_req) state_nxt = CAPT;
         CAPT:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         rd_ack        <= 1'b0;
         rd_err        <= 1'b0;
         perf_cntr_out <= '0;
         sel_q         <= '0;
         cap_q         <= '0;
         shadow_hi     <= '0;
         shadow_idx    <= '0;
         shadow_vld    <= 1'b0;
      end else begin
         state  <= state_nxt;
         rd_ack <= (state == RESP);
         if (state == IDLE && rd_req) sel_q <= sel_t'(rd_sel[4:0]);
         if (state == CAPT) cap_q <= cntr_arr[sel_q.idx];
         if (state == RESP) begin
            rd_err <= !idx_ok;
            if (!idx_ok) begin
               perf_cntr_out <= '0;
            end else if (!sel_q.hi) begin
               perf_cntr_out <= cap_q[31:0];
               shadow_hi     <= cap_q[63:32];
               shadow_idx    <= sel_q.idx;
               shadow_vld    <= 1'b1;
            end else if (shadow_hit) begin
               perf_cntr_out <= shadow_hi;
               shadow_vld    <= 1'b0;
            end else begin
               perf_cntr_out <= cap_q[63:32];
            end
         end
         // A new measurement always discards the snapshot, even one taken this cycle.
         if (perf_start) shadow_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_perf_cntr_readout.sv
// Scoreboarded bench for perf_cntr_readout: directed reads push expected
// responses with their ack cycle; a negedge monitor pops and compares.
module tb_perf_cntr_readout;

   localparam int N = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          perf_start = 1'b0;
   logic [N*64-1:0] cntr_bus = '0;
   logic          rd_req = 1'b0;
   logic [15:0]   rd_sel = '0;
   logic          rd_ack, rd_err, busy;
   logic [31:0]   perf_cntr_out;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_data = '0;

   perf_cntr_readout #(.NUM_CNTR(N)) dut (
      .clk(clk), .rst(rst), .perf_start(perf_start), .cntr_bus(cntr_bus),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_err(rd_err),
      .perf_cntr_out(perf_cntr_out), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: every ack must match the scoreboard head, including its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         last_data = '0;
      end else if (rd_ack) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack cyc=%0d data=%h err=%b", cyc, perf_cntr_out, rd_err);
         end else begin
            e = sb.pop_front();
            if (rd_err !== e.err || perf_cntr_out !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL ack got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                        perf_cntr_out, rd_err, cyc, e.data, e.err, e.cyc);
            end
            last_data = e.data;
         end
      end else begin
         if (sb.size() != 0 && cyc > sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_ack want cyc=%0d data=%h now cyc=%0d", sb[0].cyc, sb[0].data, cyc);
            void'(sb.pop_front());
         end
         checks++;
         if (perf_cntr_out !== last_data) begin
            errors++;
            $display("FAIL hold got=%h want=%h cyc=%0d", perf_cntr_out, last_data, cyc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic set_cntr(input int k, input logic [63:0] v);
      cntr_bus[64*k +: 64] = v;
   endtask

   task automatic do_read(input logic [15:0] sel, input logic [31:0] d, input logic e);
      @(negedge clk);
      rd_sel = sel;
      rd_req = 1'b1;
      sb.push_back('{e, d, cyc + 3});
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      perf_start = 1'b1;
      @(negedge clk);
      perf_start = 1'b0;
   endtask

   initial begin
      int c;
      // T1: reset dominates a pending request
      rd_req = 1'b1;
      rd_sel = 16'h0003;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ack",  {31'd0, rd_ack}, 32'd0);
      chk("rst_err",  {31'd0, rd_err}, 32'd0);
      chk("rst_out",  perf_cntr_out,  32'd0);
      chk("rst_busy", {31'd0, busy},  32'd0);
      rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // T2: coherent lo/hi pair, then shadow consumed
      set_cntr(3, 64'h0000_0001_FFFF_FFFF);
      do_read(16'h0003, 32'hFFFF_FFFF, 1'b0);
      set_cntr(3, 64'h0000_0002_0000_0000);
      do_read(16'h0013, 32'h0000_0001, 1'b0);
      do_read(16'h0013, 32'h0000_0002, 1'b0);

      // T3: hi read of another index is live; perf_start kills snapshot
      set_cntr(2, 64'h0000_0007_0000_0005);
      set_cntr(5, 64'h0000_000A_0000_0000);
      do_read(16'h0002, 32'h0000_0005, 1'b0);
      do_read(16'h0015, 32'h0000_000A, 1'b0);
      pulse_start();
      set_cntr(2, 64'h0000_0009_0000_0000);
      do_read(16'h0012, 32'h0000_0009, 1'b0);

      // T4: top valid index with junk upper sel bits, invalid indices keep shadow
      set_cntr(9, 64'h1234_5678_9ABC_DEF0);
      do_read(16'hFFE9, 32'h9ABC_DEF0, 1'b0);
      do_read(16'h000F, 32'h0000_0000, 1'b1);
      do_read(16'h001A, 32'h0000_0000, 1'b1);
      set_cntr(9, 64'hFFFF_FFFF_0000_0000);
      do_read(16'h0019, 32'h1234_5678, 1'b0);

      // T5: rd_req held 5 cycles -> two reads, three cycles apart
      set_cntr(1, 64'h0000_0055_0000_0044);
      @(negedge clk);
      c = cyc;
      rd_sel = 16'h0001;
      rd_req = 1'b1;
      sb.push_back('{1'b0, 32'h0000_0044, c + 3});
      sb.push_back('{1'b0, 32'h0000_0044, c + 6});
      repeat (5) @(negedge clk);
      rd_req = 1'b0;
      repeat (4) @(negedge clk);

      // T5b: requests and sel changes while busy are ignored
      @(negedge clk);
      c = cyc;
      rd_sel = 16'h0011;
      rd_req = 1'b1;
      sb.push_back('{1'b0, 32'h0000_0055, c + 3});
      @(negedge clk);
      rd_req = 1'b0;
      rd_sel = 16'h0000;
      @(negedge clk);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (3) @(negedge clk);

      // T6: perf_start in the RESP cycle of a lo read
      set_cntr(4, 64'h0000_0003_0000_0011);
      @(negedge clk);
      c = cyc;
      rd_sel = 16'h0004;
      rd_req = 1'b1;
      sb.push_back('{1'b0, 32'h0000_0011, c + 3});
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      perf_start = 1'b1;
      @(negedge clk);
      perf_start = 1'b0;
      set_cntr(4, 64'h0000_0006_0000_0000);
      do_read(16'h0014, 32'h0000_0006, 1'b0);

      // Reset mid-read: no ack for the aborted request
      @(negedge clk);
      rd_sel = 16'h0001;
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy},   32'd0);
      chk("abort_ack",  {31'd0, rd_ack}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      do_read(16'h0011, 32'h0000_0055, 1'b0);

      repeat (4) @(negedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
